// File: rtl/xmit_sched.sv
// Transmit frame scheduler: strict-priority grant with a starvation guard, control word
// validation, byte forwarding or discard, and an enforced inter-frame gap.
module xmit_sched #(
   parameter int MIN_LEN      = 1,
   parameter int MAX_LEN      = 1518,
   parameter int MAX_HI_BURST = 4,
   parameter int IFG_CYCLES   = 12
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        hi_ctrl_empty,
   input  logic [23:0] hi_ctrl_q,
   output logic        hi_ctrl_rd,
   input  logic        lo_ctrl_empty,
   input  logic [23:0] lo_ctrl_q,
   output logic        lo_ctrl_rd,
   output logic        hi_data_rd,
   output logic        lo_data_rd,
   output logic        data_sel,
   input  logic        out_ready,
   output logic        out_valid,
   output logic        out_sof,
   output logic        out_eof,
   output logic        discard_en,
   output logic        busy
);

   localparam int STREAK_W = ($clog2(MAX_HI_BURST + 1) < 3) ? 3 : $clog2(MAX_HI_BURST + 1);
   localparam int GAP_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

   localparam logic [11:0]         MIN_L     = 12'(MIN_LEN);
   localparam logic [11:0]         MAX_L     = 12'(MAX_LEN);
   localparam logic [STREAK_W-1:0] BURST_MAX = STREAK_W'(MAX_HI_BURST);
   localparam logic [GAP_W-1:0]    GAP_LAST  = GAP_W'(IFG_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      DROP,
      GAP
   } state_t;

   state_t              state_q, state_d;
   logic [11:0]         rem_q, rem_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                sel_q, sel_d;
   logic                first_q, first_d;

   logic                grant_hi;
   logic                grant_lo;
   logic [23:0]         ctrl_word;
   logic [11:0]         ctrl_len;
   logic                ctrl_ok;
   logic                data_rd;

   always_comb begin
      grant_hi  = !hi_ctrl_empty && (lo_ctrl_empty || (streak_q < BURST_MAX));
      grant_lo  = !grant_hi && !lo_ctrl_empty;
      ctrl_word = grant_hi ? hi_ctrl_q : lo_ctrl_q;
      ctrl_len  = ctrl_word[11:0];
      ctrl_ok   = (ctrl_word[23:12] == ctrl_len) && (ctrl_len >= MIN_L) && (ctrl_len <= MAX_L);
   end

   // The grant qualifier includes reset so no pop can escape while reset is held low.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      gap_d      = gap_q;
      streak_d   = streak_q;
      sel_d      = sel_q;
      first_d    = first_q;
      hi_ctrl_rd = 1'b0;
      lo_ctrl_rd = 1'b0;
      discard_en = 1'b0;
      data_rd    = 1'b0;
      out_valid  = 1'b0;
      out_sof    = 1'b0;
      out_eof    = 1'b0;

      case (state_q)
         IDLE: begin
            if (reset && (grant_hi || grant_lo)) begin
               hi_ctrl_rd = grant_hi;
               lo_ctrl_rd = grant_lo;
               sel_d      = grant_hi;
               rem_d      = ctrl_len;
               first_d    = 1'b1;
               gap_d      = '0;
               if (grant_hi) begin
                  if (streak_q < BURST_MAX) begin
                     streak_d = streak_q + 1'b1;
                  end
               end else begin
                  streak_d = '0;
               end
               if (ctrl_ok) begin
                  state_d = XFER;
               end else begin
                  discard_en = 1'b1;
                  state_d    = (ctrl_len == 12'd0) ? GAP : DROP;
               end
            end
         end

         XFER: begin
            if (out_ready) begin
               data_rd   = 1'b1;
               out_valid = 1'b1;
               out_sof   = first_q;
               out_eof   = (rem_q == 12'd1);
               rem_d     = rem_q - 12'd1;
               first_d   = 1'b0;
               if (rem_q == 12'd1) begin
                  state_d = GAP;
               end
            end
         end

         DROP: begin
            data_rd = 1'b1;
            rem_d   = rem_q - 12'd1;
            if (rem_q == 12'd1) begin
               state_d = GAP;
            end
         end

         GAP: begin
            if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         rem_q    <= '0;
         gap_q    <= '0;
         streak_q <= '0;
         sel_q    <= 1'b0;
         first_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         gap_q    <= gap_d;
         streak_q <= streak_d;
         sel_q    <= sel_d;
         first_q  <= first_d;
      end
   end

   assign hi_data_rd = data_rd & sel_q;
   assign lo_data_rd = data_rd & ~sel_q;
   assign data_sel   = sel_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_xmit_sched.sv
// Scoreboard bench for xmit_sched: a frame-level model predicts grant order, forwarded
// beats and discarded byte counts; a negedge monitor compares whatever the DUT presents.
module tb_xmit_sched;

   localparam int MIN_LEN      = 1;
   localparam int MAX_LEN      = 1518;
   localparam int MAX_HI_BURST = 4;
   localparam int IFG_CYCLES   = 12;

   logic        clk_sys = 1'b0;
   logic        reset   = 1'b0;
   logic        hi_ctrl_empty, lo_ctrl_empty;
   logic [23:0] hi_ctrl_q, lo_ctrl_q;
   logic        hi_ctrl_rd, lo_ctrl_rd, hi_data_rd, lo_data_rd, data_sel;
   logic        out_ready = 1'b0;
   logic        out_valid, out_sof, out_eof, discard_en, busy;

   always #5 clk_sys = ~clk_sys;

   xmit_sched #(
      .MIN_LEN     (MIN_LEN),
      .MAX_LEN     (MAX_LEN),
      .MAX_HI_BURST(MAX_HI_BURST),
      .IFG_CYCLES  (IFG_CYCLES)
   ) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .hi_ctrl_empty(hi_ctrl_empty),
      .hi_ctrl_q    (hi_ctrl_q),
      .hi_ctrl_rd   (hi_ctrl_rd),
      .lo_ctrl_empty(lo_ctrl_empty),
      .lo_ctrl_q    (lo_ctrl_q),
      .lo_ctrl_rd   (lo_ctrl_rd),
      .hi_data_rd   (hi_data_rd),
      .lo_data_rd   (lo_data_rd),
      .data_sel     (data_sel),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_sof      (out_sof),
      .out_eof      (out_eof),
      .discard_en   (discard_en),
      .busy         (busy)
   );

   typedef struct {
      logic hi;
      logic disc;
      int   len;
   } grant_t;

   typedef struct {
      logic [7:0] data;
      logic       sof;
      logic       eof;
   } beat_t;

   logic [23:0] hi_ctrl_fifo[$], lo_ctrl_fifo[$];
   logic [7:0]  hi_data_fifo[$], lo_data_fifo[$];
   logic [23:0] stg_hi_ctrl[$], stg_lo_ctrl[$];
   logic [7:0]  stg_hi_data[$], stg_lo_data[$];
   grant_t      exp_grants[$];
   beat_t       exp_beats[$];

   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_drop_reads = 0;
   int   drop_reads = 0;
   int   beat_cnt = 0;
   int   m_streak = 0;
   int   ready_mode = 0;
   int   cyc = 0;
   int   grant_cyc = 0;
   int   armed_len = 0;
   logic timing_armed = 1'b0;
   logic l_hc = 1'b0, l_lc = 1'b0, l_hd = 1'b0, l_ld = 1'b0;

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic fail_event(input string name);
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s: event seen, required none (cycle %0d)", name, cyc);
   endtask

   function automatic void refresh_fifos();
      hi_ctrl_empty = (hi_ctrl_fifo.size() == 0);
      lo_ctrl_empty = (lo_ctrl_fifo.size() == 0);
      hi_ctrl_q     = hi_ctrl_empty ? 24'h0 : hi_ctrl_fifo[0];
      lo_ctrl_q     = lo_ctrl_empty ? 24'h0 : lo_ctrl_fifo[0];
   endfunction

   task automatic add_frame(input logic hi, input logic [23:0] ctrl);
      int len;
      logic [7:0] b;
      len = int'(ctrl[11:0]);
      for (int k = 0; k < len; k++) begin
         b = 8'($urandom);
         if (hi) stg_hi_data.push_back(b);
         else    stg_lo_data.push_back(b);
      end
      if (hi) stg_hi_ctrl.push_back(ctrl);
      else    stg_lo_ctrl.push_back(ctrl);
   endtask

   // Predict the whole batch from the queue contents, then hand it to the DUT at once.
   task automatic apply_stimulus(input int mode);
      int hi_i = 0, lo_i = 0, hp = 0, lp = 0, len;
      logic hi, ok;
      logic [23:0] ctrl;
      grant_t g;
      beat_t bt;
      exp_drop_reads = 0;
      while (hi_i < stg_hi_ctrl.size() || lo_i < stg_lo_ctrl.size()) begin
         if (hi_i < stg_hi_ctrl.size() && (lo_i >= stg_lo_ctrl.size() || m_streak < MAX_HI_BURST)) begin
            hi = 1'b1;
            ctrl = stg_hi_ctrl[hi_i];
            hi_i++;
            if (m_streak < MAX_HI_BURST) m_streak++;
         end else begin
            hi = 1'b0;
            ctrl = stg_lo_ctrl[lo_i];
            lo_i++;
            m_streak = 0;
         end
         len = int'(ctrl[11:0]);
         ok  = (ctrl[23:12] == ctrl[11:0]) && (len >= MIN_LEN) && (len <= MAX_LEN);
         g.hi = hi;
         g.disc = !ok;
         g.len = len;
         exp_grants.push_back(g);
         for (int k = 0; k < len; k++) begin
            bt.data = hi ? stg_hi_data[hp] : stg_lo_data[lp];
            if (hi) hp++;
            else    lp++;
            bt.sof = (k == 0);
            bt.eof = (k == len - 1);
            if (ok) exp_beats.push_back(bt);
         end
         if (!ok) exp_drop_reads += len;
      end
      @(posedge clk_sys);
      #2;
      ready_mode   = mode;
      out_ready    = 1'b1;
      beat_cnt     = 0;
      drop_reads   = 0;
      timing_armed = 1'b0;
      foreach (stg_hi_ctrl[i]) hi_ctrl_fifo.push_back(stg_hi_ctrl[i]);
      foreach (stg_lo_ctrl[i]) lo_ctrl_fifo.push_back(stg_lo_ctrl[i]);
      foreach (stg_hi_data[i]) hi_data_fifo.push_back(stg_hi_data[i]);
      foreach (stg_lo_data[i]) lo_data_fifo.push_back(stg_lo_data[i]);
      stg_hi_ctrl.delete();
      stg_lo_ctrl.delete();
      stg_hi_data.delete();
      stg_lo_data.delete();
      refresh_fifos();
   endtask

   task automatic finish_batch(input string name, input int budget);
      int waited = 0;
      while (waited < budget && !(hi_ctrl_fifo.size() == 0 && lo_ctrl_fifo.size() == 0 && busy == 1'b0)) begin
         @(negedge clk_sys);
         waited++;
      end
      #1;
      if (waited >= budget) fail_event({name, "_timeout"});
      check_output({name, "_beats_left"}, exp_beats.size(), 0);
      check_output({name, "_grants_left"}, exp_grants.size(), 0);
      check_output({name, "_drop_reads"}, drop_reads, exp_drop_reads);
      check_output({name, "_hi_data_left"}, hi_data_fifo.size(), 0);
      check_output({name, "_lo_data_left"}, lo_data_fifo.size(), 0);
   endtask

   // FIFO side: pops requested in the previous low phase, then next out_ready value.
   always @(posedge clk_sys) begin
      cyc++;
      #1;
      if (l_hc) begin
         if (hi_ctrl_fifo.size() == 0) fail_event("hi_ctrl_underflow");
         else void'(hi_ctrl_fifo.pop_front());
      end
      if (l_lc) begin
         if (lo_ctrl_fifo.size() == 0) fail_event("lo_ctrl_underflow");
         else void'(lo_ctrl_fifo.pop_front());
      end
      if (l_hd) begin
         if (hi_data_fifo.size() == 0) fail_event("hi_data_underflow");
         else void'(hi_data_fifo.pop_front());
      end
      if (l_ld) begin
         if (lo_data_fifo.size() == 0) fail_event("lo_data_underflow");
         else void'(lo_data_fifo.pop_front());
      end
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      refresh_fifos();
   end

   // Monitor: pops the scoreboard whenever the DUT grants or forwards a byte.
   always @(negedge clk_sys) begin
      grant_t g;
      beat_t  bt;
      logic [7:0] cur;
      l_hc = reset & hi_ctrl_rd;
      l_lc = reset & lo_ctrl_rd;
      l_hd = reset & hi_data_rd;
      l_ld = reset & lo_data_rd;
      if (reset) begin
         if (timing_armed && !busy) begin
            check_output("frame_cycles", cyc - grant_cyc, 1 + armed_len + IFG_CYCLES);
            timing_armed = 1'b0;
         end
         if (hi_ctrl_rd || lo_ctrl_rd) begin
            if (hi_ctrl_rd && lo_ctrl_rd) fail_event("both_ctrl_rd");
            if (hi_data_rd || lo_data_rd) fail_event("data_rd_in_grant_cycle");
            if (exp_grants.size() == 0) begin
               fail_event("unexpected_grant");
            end else begin
               g = exp_grants.pop_front();
               check_output("grant_src_hi", hi_ctrl_rd, g.hi);
               check_output("discard_en", discard_en, g.disc);
               if (ready_mode == 0) begin
                  grant_cyc    = cyc;
                  armed_len    = g.len;
                  timing_armed = 1'b1;
               end
            end
         end else if (discard_en) begin
            fail_event("discard_without_grant");
         end
         if ((hi_data_rd && !data_sel) || (lo_data_rd && data_sel)) fail_event("data_rd_wrong_source");
         if (out_valid) begin
            check_output("valid_needs_ready", out_ready, 1);
            check_output("valid_has_read", hi_data_rd | lo_data_rd, 1);
            if (exp_beats.size() == 0) begin
               fail_event("unexpected_beat");
            end else begin
               bt = exp_beats.pop_front();
               if ((data_sel ? hi_data_fifo.size() : lo_data_fifo.size()) == 0) begin
                  fail_event("beat_from_empty_fifo");
               end else begin
                  cur = data_sel ? hi_data_fifo[0] : lo_data_fifo[0];
                  check_output("out_byte", cur, bt.data);
               end
               check_output("out_sof", out_sof, bt.sof);
               check_output("out_eof", out_eof, bt.eof);
            end
            beat_cnt++;
         end else begin
            if (out_sof || out_eof) fail_event("sof_eof_without_valid");
            if (hi_data_rd || lo_data_rd) drop_reads++;
         end
      end
   end

   initial begin
      logic [11:0] len;
      int nh, nl, kind, waited;
      hi_ctrl_fifo.push_back(24'h004004);
      refresh_fifos();
      #3;
      check_output("reset_outputs",
                   {22'd0, hi_ctrl_rd, lo_ctrl_rd, hi_data_rd, lo_data_rd, data_sel,
                    out_valid, out_sof, out_eof, discard_en, busy}, 0);
      hi_ctrl_fifo.delete();
      refresh_fifos();
      repeat (3) @(posedge clk_sys);
      #3;
      reset = 1'b1;
      @(negedge clk_sys);
      check_output("idle_after_reset_busy", busy, 0);

      for (int i = 0; i < 10; i++) begin
         add_frame(1'b1, 24'h002002);
         add_frame(1'b0, 24'h002002);
      end
      apply_stimulus(0);
      finish_batch("starvation", 2000);

      add_frame(1'b1, 24'h004004);
      apply_stimulus(0);
      finish_batch("single", 200);

      add_frame(1'b1, 24'h200201);
      apply_stimulus(0);
      finish_batch("mismatch", 2000);

      add_frame(1'b0, 24'h008008);
      apply_stimulus(1);
      finish_batch("backpressure", 200);

      add_frame(1'b1, 24'h000000);
      add_frame(1'b0, 24'h5FF5FF);
      apply_stimulus(0);
      finish_batch("bounds", 4000);

      for (int b = 0; b < 8; b++) begin
         nh = $urandom_range(0, 4);
         nl = $urandom_range(1, 4);
         for (int f = 0; f < nh + nl; f++) begin
            len  = 12'($urandom_range(1, 24));
            kind = $urandom_range(0, 9);
            if (kind == 0)      add_frame(f < nh, {len ^ 12'h001, len});
            else if (kind == 1) add_frame(f < nh, 24'h000000);
            else                add_frame(f < nh, {len, len});
         end
         apply_stimulus($urandom_range(0, 2));
         finish_batch("random", 4000);
      end

      // Saturate the high streak, then abandon a high frame mid-transfer by reset.
      for (int i = 0; i < 4; i++) add_frame(1'b1, 24'h002002);
      apply_stimulus(0);
      finish_batch("saturate", 500);
      add_frame(1'b1, 24'h008008);
      apply_stimulus(0);
      waited = 0;
      while (beat_cnt < 3 && waited < 100) begin
         @(negedge clk_sys);
         waited++;
      end
      if (waited >= 100) fail_event("mid_xfer_timeout");
      @(posedge clk_sys);
      #3;
      hi_ctrl_fifo.push_back(24'h003003);
      lo_ctrl_fifo.push_back(24'h003003);
      refresh_fifos();
      reset = 1'b0;
      #1;
      check_output("mid_reset_outputs",
                   {22'd0, hi_ctrl_rd, lo_ctrl_rd, hi_data_rd, lo_data_rd, data_sel,
                    out_valid, out_sof, out_eof, discard_en, busy}, 0);
      hi_ctrl_fifo.delete();
      lo_ctrl_fifo.delete();
      hi_data_fifo.delete();
      lo_data_fifo.delete();
      exp_grants.delete();
      exp_beats.delete();
      m_streak       = 0;
      timing_armed   = 1'b0;
      drop_reads     = 0;
      exp_drop_reads = 0;
      refresh_fifos();
      repeat (2) @(posedge clk_sys);
      #3;
      reset = 1'b1;
      #1;
      check_output("post_reset_busy", busy, 0);
      add_frame(1'b1, 24'h003003);
      add_frame(1'b0, 24'h003003);
      apply_stimulus(0);
      finish_batch("after_reset", 200);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/xmit_sched.md
# xmit_sched

Transmit frame scheduler in the clk_sys domain, in front of the PHY serializer. It picks the next frame from two queues, high and low priority, using strict priority with a starvation guard. It pops the queue's 24-bit control block, checks it, and then either streams the frame's bytes downstream under a ready handshake or drains and discards them. It also enforces a minimum inter-frame gap before the next grant.

## Interface
- MIN_LEN, 1: smallest legal frame length in bytes (must be ≥1).
- MAX_LEN, 1518: largest legal frame length in bytes (≤4095).
- MAX_HI_BURST, 4: number of consecutive high grants allowed while low is pending (≥1).
- IFG_CYCLES, 12: idle cycles inserted after every frame, forwarded or dropped (≥1).

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- hi_ctrl_empty  in  1  high control FIFO empty.
- hi_ctrl_q  in  24  high control word (show-ahead; valid when not empty).
- hi_ctrl_rd  out  1  pops the high control FIFO.
- lo_ctrl_empty / lo_ctrl_q / lo_ctrl_rd: same as above for the low queue.
- hi_data_rd  out  1  pops one byte from the high data FIFO.
- lo_data_rd  out  1  pops one byte from the low data FIFO.
- data_sel  out  1  selects the source data FIFO for the downstream mux (1 = high).
- out_ready  in  1  downstream can accept a byte this cycle.
- out_valid  out  1  a byte is forwarded downstream this cycle.
- out_sof  out  1  the current byte is the first of its frame.
- out_eof  out  1  the current byte is the last of its frame.
- discard_en  out  1  one-cycle pulse when a frame is rejected.
- busy  out  1  state is not IDLE.

## Operation
- Control word: [11:0] is the length L; [23:12] is a redundant copy of L. A frame is valid only if the two fields are equal and MIN_LEN ≤ L ≤ MAX_LEN.
- The FSM has four states: IDLE, XFER, DROP, GAP.
- IDLE, grant rule:
  - grant high if high is not empty and (low is empty or hi_streak < MAX_HI_BURST);
  - otherwise grant low if low is not empty.
- IDLE, grant cycle:
  - assert the granted ctrl_rd for exactly one cycle;
  - latch L into rem[11:0] and latch data_sel;
  - if the frame is valid, go to XFER;
  - if invalid, pulse discard_en in this same cycle, then go to DROP, or straight to GAP if L = 0.
- hi_streak (3+ bits, saturating at MAX_HI_BURST):
  - increments on each high grant, including dropped frames;
  - clears on each low grant.
- XFER: while out_ready = 1, the selected data_rd and out_valid are both asserted (combinational AND with out_ready) and rem decrements.
  - out_sof is asserted with the first byte; out_eof is asserted when rem = 1.
  - After the eof byte, go to GAP.
  - With out_ready = 0 there is no read and no output, and rem holds.
- DROP: the selected data_rd is asserted every cycle regardless of out_ready, with out_valid = 0. After L reads, go to GAP.
- GAP: count IFG_CYCLES cycles, then return to IDLE. Queue status is ignored during GAP.
- out_sof, out_eof and out_valid are never asserted outside XFER. data_rd is never asserted outside XFER/DROP.
- data_sel holds its value from grant until the next grant.

## Timing
- Reset (reset = 0) takes effect immediately, regardless of the clock:
  - state becomes IDLE; rem, the gap counter and hi_streak clear to 0;
  - data_sel = 0 and every output = 0.
- Reset in mid-frame abandons the frame. Re-synchronizing the FIFOs is the responsibility of the upstream reset.
- Grant latency: first byte read no earlier than 1 cycle after the ctrl_rd cycle.
- Throughput: an L-byte frame with out_ready held at 1 occupies 1 + L + IFG_CYCLES cycles, from IDLE back to IDLE.
- Single-byte frame (L = 1): out_sof and out_eof are asserted in the same cycle.
- If both queues become non-empty in the same cycle, the grant rule above applies.
- A grant is evaluated only in IDLE, and only one ctrl_rd is asserted per grant.

## Test plan
- Single frame: high ctrl 0x004004, out_ready = 1.
  - Required: hi_ctrl_rd for 1 cycle, then 4 consecutive hi_data_rd/out_valid cycles (sof on the 1st, eof on the 4th), then 12 GAP cycles, then IDLE with busy = 0.
- Starvation guard: both queues hold 10 frames of ctrl 0x002002, MAX_HI_BURST = 4.
  - Required grant order: H H H H L H H H H L.
- Length mismatch: ctrl 0x200201.
  - Required: discard_en pulse in the grant cycle, then exactly 513 data_rd pulses with out_valid = 0, no sof/eof, then GAP.
- Backpressure: L = 8, out_ready alternating 1/0.
  - Required: exactly 8 reads, each coincident with out_ready = 1, eof on the 8th, and no reads while out_ready = 0.
- Bounds: ctrl 0x000000 gives a discard pulse, zero reads, and goes straight to GAP. ctrl 0x5FF5FF (1535 > MAX_LEN) gives a discard pulse and 1535 reads.
- Reset mid-XFER: assert reset at byte 3 of 8.
  - Required: all outputs 0 asynchronously. After release, busy = 0 and the next high grant occurs even with low pending, because hi_streak = 0.
